// File: rtl/instr_pkg.sv
// Shared definitions for the instruction field decoder:
// parcel/address widths, word field positions, assembly FSM states.
package instr_pkg;

    localparam int PARCEL_W     = 16;
    localparam int ADDR_W       = 48;
    localparam int ADDR_PARCELS = ADDR_W / PARCEL_W;
    localparam int WORD_W       = 2 * PARCEL_W;

    localparam int MAJOR_HI    = 31;
    localparam int MAJOR_LO    = 28;
    localparam int SRC1_HI     = 27;
    localparam int SRC1_LO     = 23;
    localparam int SRC2_HI     = 22;
    localparam int SRC2_LO     = 18;
    localparam int SCALE_HI    = 17;
    localparam int SCALE_LO    = 16;
    localparam int DEST_HI     = 15;
    localparam int DEST_LO     = 11;
    localparam int MINOR_HI    = 10;
    localparam int MINOR_LO    = 7;
    localparam int HASADDR_BIT = 6;
    localparam int OFFSUB_BIT  = 5;
    localparam int RSVD_HI     = 4;
    localparam int RSVD_LO     = 0;

    typedef enum logic [2:0] {
        S_HI,
        S_LO,
        S_A0,
        S_A1,
        S_A2
    } state_t;

    typedef struct packed {
        logic [3:0] major;
        logic [4:0] src1;
        logic [4:0] src2;
        logic [1:0] scale;
        logic [4:0] dest;
        logic [3:0] minor;
        logic       has_addr;
        logic       off_sub;
    } fields_t;

endpackage

// File: rtl/instr_field_split.sv
// Combinational split of a 32-bit base instruction word into queue fields.
// Also flags a nonzero reserved field; reusable by queue-side checkers.
module instr_field_split
    import instr_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    output fields_t           fields,
    output logic              rsvd_nz
);

    assign fields.major    = word[MAJOR_HI:MAJOR_LO];
    assign fields.src1     = word[SRC1_HI:SRC1_LO];
    assign fields.src2     = word[SRC2_HI:SRC2_LO];
    assign fields.scale    = word[SCALE_HI:SCALE_LO];
    assign fields.dest     = word[DEST_HI:DEST_LO];
    assign fields.minor    = word[MINOR_HI:MINOR_LO];
    assign fields.has_addr = word[HASADDR_BIT];
    assign fields.off_sub  = word[OFFSUB_BIT];
    assign rsvd_nz         = |word[RSVD_HI:RSVD_LO];

endmodule

// File: rtl/instr_field_decoder.sv
// Assembles 16-bit fetch parcels into a decoded, registered instruction.
// Optional reserved-bit check: define INSTR_RESERVED_CHECK_EN.
module instr_field_decoder
    import instr_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush_in,
    input  logic [PARCEL_W-1:0] parcel_in,
    input  logic                parcel_valid_in,
    output logic                stall_out,
    input  logic                stall_in,
    output logic                valid_out,
    output logic [3:0]          MajorOpcode_out,
    output logic [4:0]          Source1_out,
    output logic [4:0]          Source2_out,
    output logic [1:0]          OffsetScale_out,
    output logic [4:0]          Destination_out,
    output logic [3:0]          MinorOpcode_out,
    output logic                HasAddress_out,
    output logic                OffsetSub_out,
    output logic [ADDR_W-1:0]   Address_out,
    output logic                illegal_out
);

    localparam int ALO_W = ADDR_W - PARCEL_W;

    state_t              state;
    state_t              state_nxt;
    logic [WORD_W-1:0]   word_q;
    logic [ALO_W-1:0]    addr_q;
    logic                accept;
    logic                complete;
    logic [WORD_W-1:0]   word_c;
    logic [ADDR_W-1:0]   addr_c;
    fields_t             fields_c;
    fields_t             fields_q;
    logic                rsvd_nz;

    // The held instruction blocks fetch only while the queue refuses it.
    assign stall_out = valid_out && stall_in;
    assign accept    = parcel_valid_in && !stall_out && !flush_in;

    instr_field_split u_split (
        .word    (word_c),
        .fields  (fields_c),
        .rsvd_nz (rsvd_nz)
    );

    // Next state, completion detect and the word/address to present.
    always_comb begin
        state_nxt = state;
        complete  = 1'b0;
        word_c    = {word_q[WORD_W-1:PARCEL_W], parcel_in};
        addr_c    = '0;
        if (accept) begin
            case (state)
                S_HI: state_nxt = S_LO;
                S_LO: begin
                    if (parcel_in[HASADDR_BIT]) begin
                        state_nxt = S_A0;
                    end else begin
                        state_nxt = S_HI;
                        complete  = 1'b1;
                    end
                end
                S_A0: state_nxt = S_A1;
                S_A1: state_nxt = S_A2;
                S_A2: begin
                    state_nxt = S_HI;
                    complete  = 1'b1;
                    word_c    = word_q;
                    addr_c    = {parcel_in, addr_q};
                end
                default: state_nxt = S_HI;
            endcase
        end
        if (flush_in) begin
            state_nxt = S_HI;
        end
    end

    // Assembly FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_HI;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture word and low address parcels as they are accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
            addr_q <= '0;
        end else if (flush_in) begin
            word_q <= '0;
            addr_q <= '0;
        end else if (accept) begin
            case (state)
                S_HI: word_q[WORD_W-1:PARCEL_W] <= parcel_in;
                S_LO: word_q[PARCEL_W-1:0]      <= parcel_in;
                S_A0: addr_q[PARCEL_W-1:0]      <= parcel_in;
                S_A1: addr_q[ALO_W-1:PARCEL_W]  <= parcel_in;
                default: ;
            endcase
        end
    end

    // Output register: load on completion, drop valid once taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out   <= 1'b0;
            fields_q    <= '0;
            Address_out <= '0;
        end else if (flush_in) begin
            valid_out <= 1'b0;
        end else if (complete) begin
            valid_out   <= 1'b1;
            fields_q    <= fields_c;
            Address_out <= addr_c;
        end else if (!stall_in) begin
            valid_out <= 1'b0;
        end
    end

`ifdef INSTR_RESERVED_CHECK_EN
    // Reserved-field flag travels with the instruction it belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_out <= 1'b0;
        end else if (!flush_in && complete) begin
            illegal_out <= rsvd_nz;
        end
    end
`else
    logic unused_rsvd;
    assign unused_rsvd = rsvd_nz;
    assign illegal_out = 1'b0;
`endif

    assign MajorOpcode_out = fields_q.major;
    assign Source1_out     = fields_q.src1;
    assign Source2_out     = fields_q.src2;
    assign OffsetScale_out = fields_q.scale;
    assign Destination_out = fields_q.dest;
    assign MinorOpcode_out = fields_q.minor;
    assign HasAddress_out  = fields_q.has_addr;
    assign OffsetSub_out   = fields_q.off_sub;

endmodule

// File: tb/tb_instr_field_decoder.sv
// Scoreboard bench for instr_field_decoder: directed scenarios then
// randomized parcels/stalls/flushes against a parcel-list reference model.
module tb_instr_field_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush_in = 1'b0;
    logic [15:0] parcel_in = '0;
    logic        parcel_valid_in = 1'b0;
    logic        stall_in = 1'b0;
    logic        stall_out;
    logic        valid_out;
    logic [3:0]  MajorOpcode_out;
    logic [4:0]  Source1_out;
    logic [4:0]  Source2_out;
    logic [1:0]  OffsetScale_out;
    logic [4:0]  Destination_out;
    logic [3:0]  MinorOpcode_out;
    logic        HasAddress_out;
    logic        OffsetSub_out;
    logic [47:0] Address_out;
    logic        illegal_out;

    instr_field_decoder dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flush_in        (flush_in),
        .parcel_in       (parcel_in),
        .parcel_valid_in (parcel_valid_in),
        .stall_out       (stall_out),
        .stall_in        (stall_in),
        .valid_out       (valid_out),
        .MajorOpcode_out (MajorOpcode_out),
        .Source1_out     (Source1_out),
        .Source2_out     (Source2_out),
        .OffsetScale_out (OffsetScale_out),
        .Destination_out (Destination_out),
        .MinorOpcode_out (MinorOpcode_out),
        .HasAddress_out  (HasAddress_out),
        .OffsetSub_out   (OffsetSub_out),
        .Address_out     (Address_out),
        .illegal_out     (illegal_out)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    logic [75:0] sb[$];
    int unsigned pq[$];
    bit          mvalid = 1'b0;
    bit          acc;

    function automatic logic [75:0] actual();
        return {MajorOpcode_out, Source1_out, Source2_out, OffsetScale_out,
                Destination_out, MinorOpcode_out, HasAddress_out,
                OffsetSub_out, Address_out, illegal_out};
    endfunction

    function automatic void chk(string name, logic [79:0] act, logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endfunction

    // Reference: decode the accepted parcel list with plain arithmetic.
    function automatic logic [75:0] model_instr();
        int unsigned w;
        longint      a;
        bit          ill;
        w = pq[0] * 65536 + pq[1];
        a = 0;
        if (pq.size() == 5)
            a = longint'(pq[4]) * 64'h1_0000_0000 + longint'(pq[3]) * 65536
                + longint'(pq[2]);
`ifdef INSTR_RESERVED_CHECK_EN
        ill = (w % 32) != 0;
`else
        ill = 1'b0;
`endif
        return {4'(w >> 28), 5'((w >> 23) % 32), 5'((w >> 18) % 32),
                2'((w >> 16) % 4), 5'((w >> 11) % 32), 4'((w >> 7) % 16),
                1'((w >> 6) % 2), 1'((w >> 5) % 2), 48'(a), ill};
    endfunction

    // One clock cycle of stimulus plus handshake/valid model update.
    task automatic cyc(input bit pv, input logic [15:0] p, input bit st,
                       input bit fl, output bit a);
        bit mstall;
        bit done;
        @(posedge clk);
        #2;
        parcel_valid_in = pv;
        parcel_in       = p;
        stall_in        = st;
        flush_in        = fl;
        #6;
        mstall = mvalid && st;
        chk("stall_out", 80'(stall_out), 80'(mstall));
        chk("valid_out", 80'(valid_out), 80'(mvalid));
        a    = 1'b0;
        done = 1'b0;
        if (fl) begin
            pq.delete();
            sb.delete();
            mvalid = 1'b0;
        end else begin
            a = pv && !mstall;
            if (a) begin
                pq.push_back(int'(p));
                if ((pq.size() == 2 && ((pq[1] >> 6) % 2) == 0) || pq.size() == 5) begin
                    sb.push_back(model_instr());
                    pq.delete();
                    done = 1'b1;
                end
            end
            mvalid = done ? 1'b1 : (st ? mvalid : 1'b0);
        end
    endtask

    task automatic put(input logic [15:0] p);
        bit a;
        cyc(1'b1, p, 1'b0, 1'b0, a);
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) cyc(1'b0, 16'h0, 1'b0, 1'b0, a);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n           = 1'b0;
        parcel_valid_in = 1'b0;
        stall_in        = 1'b0;
        flush_in        = 1'b0;
        #1;
        chk("async_reset", {2'b0, valid_out, stall_out, actual()}, 80'h0);
        pq.delete();
        sb.delete();
        mvalid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Monitor: compare each instruction the queue takes with the scoreboard.
    initial begin
        forever begin
            @(posedge clk);
            #9;
            if (rst_n && valid_out && !stall_in && !flush_in) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_instr actual=%h required=none", actual());
                end else begin
                    chk("instr", 80'(actual()), 80'(sb.pop_front()));
                end
            end
        end
    end

    initial begin
        #1;
        chk("reset_state", {2'b0, valid_out, stall_out, actual()}, 80'h0);
        #11;
        rst_n = 1'b1;

        put(16'h3089); put(16'h22A0); idle(3);

        put(16'h3089); put(16'h22E0); put(16'h5678); put(16'h1234);
        put(16'hABCD); idle(2);

        put(16'h3089); put(16'h22A0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 16'h3089, 1'b1, 1'b0, acc);
        put(16'h3089); put(16'h22A0); idle(3);

        put(16'h3089); put(16'h22E0); put(16'h5678);
        cyc(1'b1, 16'h1111, 1'b0, 1'b1, acc);
        put(16'h3089); put(16'h22A0); idle(2);

        put(16'h3089); put(16'h22A1); idle(2);

        put(16'h3089); put(16'h22A0);
        cyc(1'b0, 16'h0, 1'b1, 1'b0, acc);
        do_reset();
        put(16'h3089); put(16'h22A0); idle(2);

        put(16'h3089); put(16'h22A0); idle(1);
        put(16'h3089); put(16'h22E0); put(16'h5678);
        do_reset();
        put(16'h3089); put(16'h22A0); idle(2);

        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom % 4) != 0, 16'($urandom), ($urandom % 3) == 0,
                ($urandom % 50) == 0, acc);
        end
        idle(6);
        chk("sb_empty", 80'(sb.size()), 80'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
